// File: rtl/hw7lp_pkg.sv
// Shared constants for the HW7 ALU: instruction classes, ARM data-processing
// opcodes and the bit positions of the NZCV flags.
package hw7lp_pkg;

  // Instruction class carried on op
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // ARM data-processing opcodes carried on cmd
  localparam logic [3:0] OPC_AND = 4'b0000;
  localparam logic [3:0] OPC_EOR = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_RSB = 4'b0011;
  localparam logic [3:0] OPC_ADD = 4'b0100;
  localparam logic [3:0] OPC_ADC = 4'b0101;
  localparam logic [3:0] OPC_SBC = 4'b0110;
  localparam logic [3:0] OPC_RSC = 4'b0111;
  localparam logic [3:0] OPC_TST = 4'b1000;
  localparam logic [3:0] OPC_TEQ = 4'b1001;
  localparam logic [3:0] OPC_CMP = 4'b1010;
  localparam logic [3:0] OPC_CMN = 4'b1011;
  localparam logic [3:0] OPC_ORR = 4'b1100;
  localparam logic [3:0] OPC_MOV = 4'b1101;
  localparam logic [3:0] OPC_BIC = 4'b1110;
  localparam logic [3:0] OPC_MVN = 4'b1111;

  // Positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Memory-class U bit: 1 adds the offset, 0 subtracts it
  localparam int MEM_U_BIT = 3;

endpackage

// File: rtl/hw7lp_addsub.sv
// Combinational WIDTH-bit adder/subtractor. Subtraction is a + ~b + cin, so
// cout is the ARM "not borrow" carry and ovf is the signed overflow of the
// operation actually performed.
module hw7lp_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   total;

  // Invert b for subtraction, then one wide add exposes the carry out
  always_comb begin
    b_eff = sub ? ~b : b;
    total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    sum   = total[WIDTH-1:0];
    cout  = total[WIDTH];
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/hw7lp_alu.sv
// Registered ALU / address-generation unit for the HW7 datapath. A single
// shared adder serves the data-processing arithmetic ops as well as the
// memory and branch address paths; result and NZCV are captured every clock.
module hw7lp_alu
  import hw7lp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  input  logic [1:0]       op,
  input  logic [3:0]       cmd,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flag
);

  logic [WIDTH-1:0] as_a;
  logic [WIDTH-1:0] as_b;
  logic             as_cin;
  logic             as_sub;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_ovf;

  logic             use_adder;
  logic [WIDTH-1:0] result;
  logic [3:0]       next_flag;
  logic             carry_in;

  assign carry_in = flag[FLAG_C];

  hw7lp_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .cin  (as_cin),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  // Steer operands into the shared adder; reverse-subtracts swap A and B,
  // and ADC/SBC/RSC feed the registered carry back in
  always_comb begin
    as_a      = portA;
    as_b      = portB;
    as_cin    = 1'b0;
    as_sub    = 1'b0;
    use_adder = 1'b0;
    case (op)
      OP_DP: begin
        case (cmd)
          OPC_SUB, OPC_CMP: begin
            as_sub    = 1'b1;
            as_cin    = 1'b1;
            use_adder = 1'b1;
          end
          OPC_RSB: begin
            as_a      = portB;
            as_b      = portA;
            as_sub    = 1'b1;
            as_cin    = 1'b1;
            use_adder = 1'b1;
          end
          OPC_ADD, OPC_CMN: begin
            use_adder = 1'b1;
          end
          OPC_ADC: begin
            as_cin    = carry_in;
            use_adder = 1'b1;
          end
          OPC_SBC: begin
            as_sub    = 1'b1;
            as_cin    = carry_in;
            use_adder = 1'b1;
          end
          OPC_RSC: begin
            as_a      = portB;
            as_b      = portA;
            as_sub    = 1'b1;
            as_cin    = carry_in;
            use_adder = 1'b1;
          end
          default: use_adder = 1'b0;
        endcase
      end
      OP_MEM: begin
        as_sub = ~cmd[MEM_U_BIT];
        as_cin = ~cmd[MEM_U_BIT];
      end
      default: as_sub = 1'b0;
    endcase
  end

  // Select the result per class/opcode; compare and test ops still drive out
  always_comb begin
    result = '0;
    case (op)
      OP_DP: begin
        case (cmd)
          OPC_AND, OPC_TST: result = portA & portB;
          OPC_EOR, OPC_TEQ: result = portA ^ portB;
          OPC_ORR:          result = portA | portB;
          OPC_MOV:          result = portB;
          OPC_BIC:          result = portA & ~portB;
          OPC_MVN:          result = ~portB;
          default:          result = as_sum;
        endcase
      end
      OP_MEM, OP_BR: result = as_sum;
      default:       result = '0;
    endcase
  end

  // Only data-processing ops touch NZCV; logical ops clear C and V
  always_comb begin
    next_flag = flag;
    if (op == OP_DP) begin
      next_flag[FLAG_N] = result[WIDTH-1];
      next_flag[FLAG_Z] = (result == '0);
      next_flag[FLAG_C] = use_adder & as_cout;
      next_flag[FLAG_V] = use_adder & as_ovf;
    end
  end

  // Capture result and flags every edge; reset clears both immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      flag <= 4'b0000;
    end else begin
      out  <= result;
      flag <= next_flag;
    end
  end

endmodule

// File: tb/tb_hw7lp_alu.sv
// Self-checking bench for hw7lp_alu: directed vectors, flag corner cases,
// reset and latency behaviour, and randomized traffic against an
// arithmetic reference model.
module tb_hw7lp_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] portA;
  logic [31:0] portB;
  logic [1:0]  op;
  logic [3:0]  cmd;
  logic [31:0] out;
  logic [3:0]  flag;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_out;
  logic [3:0]  exp_flag;
  logic [3:0]  model_flag;

  hw7lp_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .portA (portA),
    .portB (portB),
    .op    (op),
    .cmd   (cmd),
    .out   (out),
    .flag  (flag)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed overflow of a 64-bit exact result viewed as 32-bit
  function automatic bit sovf(input longint r);
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Exact arithmetic: x + y + k
  function automatic void add_ref(input logic [31:0] x, input logic [31:0] y, input int k,
                                  output logic [31:0] r, output bit c, output bit v);
    longint unsigned ut;
    longint st;
    ut = longint'(x) + longint'(y) + longint'(k);
    st = longint'($signed(x)) + longint'($signed(y)) + longint'(k);
    r  = ut[31:0];
    c  = (ut >= 64'h1_0000_0000);
    v  = sovf(st);
  endfunction

  // Exact arithmetic: m - s - bi, C meaning "no borrow"
  function automatic void sub_ref(input logic [31:0] m, input logic [31:0] s, input int bi,
                                  output logic [31:0] r, output bit c, output bit v);
    longint st;
    longint unsigned um, us;
    um = longint'(m);
    us = longint'(s) + longint'(bi);
    st = longint'($signed(m)) - longint'($signed(s)) - longint'(bi);
    r  = m - s - bi[31:0];
    c  = (um >= us);
    v  = sovf(st);
  endfunction

  // Reference model of one clocked operation
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] o, input logic [3:0] c,
                                    input logic [3:0] fin,
                                    output logic [31:0] r, output logic [3:0] f);
    bit cy, vv, cin;
    cin = fin[1];
    cy  = 1'b0;
    vv  = 1'b0;
    r   = 32'h0;
    f   = fin;
    case (o)
      2'd0: begin
        case (c)
          4'd0, 4'd8: r = a & b;
          4'd1, 4'd9: r = a ^ b;
          4'd2, 4'd10: sub_ref(a, b, 0, r, cy, vv);
          4'd3: sub_ref(b, a, 0, r, cy, vv);
          4'd4, 4'd11: add_ref(a, b, 0, r, cy, vv);
          4'd5: add_ref(a, b, int'(cin), r, cy, vv);
          4'd6: sub_ref(a, b, int'(!cin), r, cy, vv);
          4'd7: sub_ref(b, a, int'(!cin), r, cy, vv);
          4'd12: r = a | b;
          4'd13: r = b;
          4'd14: r = a & ~b;
          default: r = ~b;
        endcase
        f = {r[31], (r == 32'h0), cy, vv};
      end
      2'd1: r = c[3] ? (a + b) : (a - b);
      2'd2: r = a + b;
      default: r = 32'h0;
    endcase
  endfunction

  // Drive one operation, let it be captured, and advance the model
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] o, input logic [3:0] c);
    portA = a;
    portB = b;
    op    = o;
    cmd   = c;
    ref_model(a, b, o, c, model_flag, exp_out, exp_flag);
    @(posedge clk);
    #1;
    model_flag = exp_flag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    portA = 32'h0; portB = 32'h0; op = 2'd3; cmd = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h0 || flag !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_initial out=%h flag=%b want 0/0000", out, flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_flag = 4'h0;
    applyStimulus(32'h0, 32'h8000ABCD, 2'd0, 4'd13);
    checks++;
    if (out !== 32'h8000ABCD || flag !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL pre_reset_mov out=%h flag=%b want 8000abcd/1000", out, flag);
    end
    // assert reset mid-cycle with a pending result on the inputs
    portB = 32'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 32'h0 || flag !== 4'h0) begin
      errors++;
      $display("[TB] FAIL async_reset out=%h flag=%b want 0/0000", out, flag);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h0 || flag !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_hold out=%h flag=%b want 0/0000", out, flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_flag = 4'h0;
    applyStimulus(32'h0, 32'h0, 2'd3, 4'd0);
    checks++;
    if (out !== 32'h0 || flag !== 4'h0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset out=%h flag=%b want 0/0000", out, flag);
    end
  endtask

  task automatic test_dp_vectors();
    logic [3:0]  cmds [6]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd12, 4'd10};
    logic [31:0] outs [6]  = '{32'h00011110, 32'h00011110, 32'hFFFEEEF0,
                               32'h00011112, 32'h00011111, 32'h00011110};
    logic [3:0]  flgs [6]  = '{4'b0000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0010};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'h00011111, 32'h00000001, 2'd0, cmds[i]);
      checks++;
      if (out !== outs[i] || flag !== flgs[i]) begin
        errors++;
        $display("[TB] FAIL dp_cmd%0d out=%h flag=%b want %h/%b", cmds[i], out, flag, outs[i], flgs[i]);
      end
    end
  endtask

  task automatic test_flag_edges();
    applyStimulus(32'h7FFFFFFF, 32'h1, 2'd0, 4'd4);
    checks++;
    if (out !== 32'h80000000 || flag !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL add_ovf out=%h flag=%b want 80000000/1001", out, flag);
    end
    applyStimulus(32'd5, 32'd5, 2'd0, 4'd2);
    checks++;
    if (out !== 32'h0 || flag !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL sub_zero out=%h flag=%b want 0/0110", out, flag);
    end
    // prior C=1 from the subtract above
    applyStimulus(32'hFFFFFFFF, 32'h0, 2'd0, 4'd5);
    checks++;
    if (out !== 32'h0 || flag !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL adc_carry out=%h flag=%b want 0/0110", out, flag);
    end
  endtask

  task automatic test_mem_branch_reserved();
    applyStimulus(32'd15, 32'd14, 2'd1, 4'b0000);
    checks++;
    if (out !== 32'd1 || flag !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL mem_down out=%h flag=%b want 1/0110", out, flag);
    end
    applyStimulus(32'd15, 32'd14, 2'd1, 4'b1000);
    checks++;
    if (out !== 32'd29 || flag !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL mem_up out=%h flag=%b want 1d/0110", out, flag);
    end
    applyStimulus(32'hFFFFFFFF, 32'd10, 2'd2, 4'b0100);
    checks++;
    if (out !== 32'h9 || flag !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL branch_wrap out=%h flag=%b want 9/0110", out, flag);
    end
    applyStimulus(32'hDEADBEEF, 32'h12345678, 2'd3, 4'b0100);
    checks++;
    if (out !== 32'h0 || flag !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL reserved out=%h flag=%b want 0/0110", out, flag);
    end
  endtask

  task automatic test_latency();
    logic [31:0] held_out;
    logic [3:0]  held_flag;
    applyStimulus(32'h10, 32'h20, 2'd0, 4'd4);
    held_out  = exp_out;
    held_flag = exp_flag;
    // change inputs between edges; registered outputs must not move
    portA = 32'h80000000;
    portB = 32'h80000000;
    cmd   = 4'd4;
    #3;
    checks++;
    if (out !== held_out || flag !== held_flag) begin
      errors++;
      $display("[TB] FAIL latency_hold out=%h flag=%b want %h/%b", out, flag, held_out, held_flag);
    end
    applyStimulus(32'h80000000, 32'h80000000, 2'd0, 4'd4);
    checks++;
    if (out !== 32'h0 || flag !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL latency_update out=%h flag=%b want 0/0111", out, flag);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: a = 32'hFFFFFFFF;
        1: b = a;
        default: ;
      endcase
      applyStimulus(a, b, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      checks++;
      if (out !== exp_out || flag !== exp_flag) begin
        errors++;
        $display("[TB] FAIL random_%0d op=%0d cmd=%0d a=%h b=%h out=%h flag=%b want %h/%b",
                 i, op, cmd, a, b, out, flag, exp_out, exp_flag);
      end
    end
  endtask

  initial begin
    model_flag = 4'h0;
    test_reset();
    test_dp_vectors();
    test_flag_edges();
    test_mem_branch_reserved();
    test_latency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
